add_checker: RTL
================

# add_checker

Self-checking consumer that sits directly downstream of the `add` stage. It taps the same operands driven into `add` (`a`, `b`, `en`) plus the stage's registered `out`. It rebuilds the expected sum one cycle behind and compares it against the actual result. It keeps pass/mismatch counters, captures the first failure and exposes a small status FSM so VPI tasks (`$show_all_signals`) and benches can read health at any time.

## Interface
Parameters:
- `WIDTH`, 32, operand/sum width; must match `add`.
- `CNT_W`, 16, width of both counters and the failure index.
- `STOP_ON_FAIL`, 0, when 1 the block halts checking after the first mismatch.

Ports:
- `clk`  in  1  sole clock; same clock as `add`.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous clear of all state; same effect as reset.
- `en`  in  1  operands `a`/`b` presented to `add` this cycle are to be checked.
- `a`  in  WIDTH  operand a as driven into `add`.
- `b`  in  WIDTH  operand b as driven into `add`.
- `sum`  in  WIDTH  `add` output `out`.
- `chk_cnt`  out  CNT_W  number of comparisons performed, saturating.
- `err_cnt`  out  CNT_W  number of mismatches, saturating.
- `err`  out  1  sticky: at least one mismatch since reset/clear.
- `first_exp`  out  WIDTH  expected value at the first mismatch.
- `first_act`  out  WIDTH  actual `sum` at the first mismatch.
- `first_idx`  out  CNT_W  `chk_cnt` value (0-based) of the first mismatch.
- `state`  out  2  0 = IDLE, 1 = ACTIVE, 2 = HALT.

## Operation
**Capture stage.** On each posedge with `en` = 1, register:
- `exp_q` = (`a` + `b`) mod 2^WIDTH; the carry is discarded exactly as in `add`.
- `vld_q` = 1.

With `en` = 0, `vld_q` is set to 0.

**Compare stage.** On each posedge with `vld_q` = 1 and `state` != HALT, compare `sum` with `exp_q`.
- Any X/Z bit in `sum` counts as a mismatch.
- `chk_cnt` increments on every comparison.
- `err_cnt` increments on each mismatch.
- Both counters saturate at 2^CNT_W-1 and never wrap.

**First-failure capture.** On a mismatch while `err` = 0:
- Load `first_exp`, `first_act` and `first_idx` (the pre-increment `chk_cnt`).
- Set `err`.

Later mismatches do not overwrite these fields.

**FSM.**
- IDLE -> ACTIVE on the first comparison.
- ACTIVE -> HALT on a mismatch when `STOP_ON_FAIL` = 1. The comparison that causes the mismatch is still counted.
- With `STOP_ON_FAIL` = 0, HALT is never entered.
- HALT is left only by `rst` or `clear`.
- In HALT, all counters and capture registers freeze, and the capture stage keeps running with no effect.

**Reset/clear.** `rst` (async) or `clear` (sync) sets all outputs, `exp_q` and `vld_q` to 0 and `state` to IDLE.
- `clear` dominates `en` and `vld_q` in the same cycle: that sample is dropped and any pending compare is discarded.
- Reset mid-stream discards the in-flight operand pair.

## Timing
- `en`/`a`/`b` are sampled at edge t, the same edge at which `add` registers `a`+`b`. The comparison happens at edge t+1 against `sum`.
- Counter, `err` and `state` updates are visible after edge t+1. Latency from operand to status is 2 edges.
- Back-to-back `en` is fully pipelined: one comparison per cycle, no bubbles, no backpressure.
- `sum` is not checked on cycles where `vld_q` = 0. `add` has no reset, so its X output before the first clock is ignored.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- **Reset check:** assert `rst` mid-cycle -> all outputs 0 immediately, `state` = IDLE.
- **Clean stream:** `a` = 5 and `b` = 0..9 with `en` = 1 for 10 cycles, `sum` driven by a real `add` -> `chk_cnt` = 10, `err_cnt` = 0, `err` = 0, `state` = ACTIVE two edges after the first `en`.
- **Wrap-around:** `a` = 32'hFFFF_FFFF, `b` = 2 -> expected 1, no error. Force `sum` = 0 for one cycle of a stream starting at `chk_cnt` = 3 -> `err` = 1, `first_exp`/`first_act`/`first_idx` = 1/0/3, `err_cnt` = 1.
- **Stop on fail:** `STOP_ON_FAIL` = 1, inject a mismatch on the 2nd comparison, then 5 more valid pairs -> `chk_cnt` = 2, `err_cnt` = 1, `state` = HALT. Then `clear` -> all 0, `state` = IDLE.
- **Saturation:** `CNT_W` = 4, forced `sum` mismatches on 20 consecutive `en` cycles -> `chk_cnt` = `err_cnt` = 15, `first_idx` = 0.
- **Clear collision:** `clear` coincident with `en`, and `rst` asserted while `vld_q` = 1 -> no counter increment on the following edge.

Source files
------------

// File: rtl/add_checker.sv
// ---------------------------------------------------------------------------
// add_checker
//   Self-checking monitor placed behind the `add` stage. It taps the operands
//   driven into `add`, rebuilds the expected sum one cycle later and compares
//   it against `add`'s registered output. It keeps saturating pass/mismatch
//   counters, latches the first failure and exposes a small status FSM.
//
// Parameters
//   WIDTH        operand/sum width, must match `add`
//   CNT_W        width of chk_cnt, err_cnt and first_idx
//   STOP_ON_FAIL 1: stop checking (HALT) after the first mismatch
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   clear        synchronous clear, same effect as rst
//   en, a, b     operand pair presented to `add` this cycle
//   sum          `add` registered output
//   chk_cnt      comparisons performed (saturating)
//   err_cnt      mismatches seen (saturating)
//   err          sticky: at least one mismatch
//   first_exp    expected value at the first mismatch
//   first_act    observed sum at the first mismatch
//   first_idx    0-based comparison index of the first mismatch
//   state        0 IDLE, 1 ACTIVE, 2 HALT
// ---------------------------------------------------------------------------
module add_checker #(
    parameter int WIDTH        = 32,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act,
    output logic [CNT_W-1:0] first_idx,
    output logic [1:0]       state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_HALT   = 2'd2;

    logic [WIDTH-1:0] exp_q;
    logic             vld_q;
    logic             cmp;
    logic             mis;

    assign cmp = vld_q && (state != S_HALT);
    // Case inequality so that any X/Z bit on sum is reported as a mismatch.
    assign mis = (sum !== exp_q);

    // Capture stage: mirrors the add register, carry dropped by width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= '0;
            vld_q <= 1'b0;
        end else if (clear) begin
            exp_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= en;
            if (en)
                exp_q <= a + b;
        end
    end

    // Compare stage, counters, first-failure capture and status FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_cnt   <= '0;
            err_cnt   <= '0;
            err       <= 1'b0;
            first_exp <= '0;
            first_act <= '0;
            first_idx <= '0;
            state     <= S_IDLE;
        end else if (clear) begin
            chk_cnt   <= '0;
            err_cnt   <= '0;
            err       <= 1'b0;
            first_exp <= '0;
            first_act <= '0;
            first_idx <= '0;
            state     <= S_IDLE;
        end else if (cmp) begin
            if (chk_cnt != '1)
                chk_cnt <= chk_cnt + 1'b1;
            if (mis) begin
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
                if (!err) begin
                    err       <= 1'b1;
                    first_exp <= exp_q;
                    first_act <= sum;
                    first_idx <= chk_cnt;
                end
            end
            // A failing first comparison with STOP_ON_FAIL goes straight to HALT.
            if (mis && (STOP_ON_FAIL != 0))
                state <= S_HALT;
            else
                state <= S_ACTIVE;
        end
    end

endmodule
